// File: rtl/sched_acc_allocator.sv
`default_nettype none
// ============================================================================
// Module      : sched_acc_allocator
// Description : Allocates one accelerator instance to a task request. The
//               task type is looked up in the scheduling data memory (read
//               port B), then the type's instance range is searched for a
//               non-busy accelerator. A busy bitmap tracks allocations and
//               is cleared through the free port.
//               Optional feature macro: SCHED_ROUND_ROBIN_EN (per-type
//               round-robin start offset for the instance search).
// Revision    : 1.0 - initial release
// ============================================================================
module sched_acc_allocator #(
    parameter int MAX_ACCS               = 16,
    parameter int MAX_ACC_TYPES          = 16,
    parameter int ACC_BITS               = $clog2(MAX_ACCS),
    parameter int ACC_TYPE_BITS          = $clog2(MAX_ACC_TYPES),
    parameter int SCHED_DATA_BITS        = 48,
    parameter int SCHED_DATA_ACCID_L     = 0,
    parameter int SCHED_DATA_COUNT_L     = 8,
    parameter int SCHED_DATA_TASK_TYPE_L = 16,
    parameter int SCHED_DATA_TASK_TYPE_H = 47,
    parameter int SCHED_TASKTYPE_BITS    = SCHED_DATA_TASK_TYPE_H - SCHED_DATA_TASK_TYPE_L + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ACC_TYPE_BITS:0]         num_acc_types,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SCHED_TASKTYPE_BITS-1:0] req_task_type,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [1:0]                     resp_code,
    output logic [ACC_BITS-1:0]            resp_acc_id,
    output logic [ACC_TYPE_BITS-1:0]       scheduleData_portB_addr,
    output logic                           scheduleData_portB_en,
    input  logic [SCHED_DATA_BITS-1:0]     scheduleData_portB_dout,
    input  logic                           free_valid,
    input  logic [ACC_BITS-1:0]            free_acc_id,
    output logic [MAX_ACCS-1:0]            busy_mask
);

    localparam logic [1:0] c_RESP_GRANT   = 2'b00;
    localparam logic [1:0] c_RESP_BUSY    = 2'b01;
    localparam logic [1:0] c_RESP_UNKNOWN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_LOOKUP_ISSUE = 3'd1,
        S_LOOKUP_CHECK = 3'd2,
        S_SEARCH       = 3'd3,
        S_RESP         = 3'd4
    } state_t;

    state_t                           r_state;
    state_t                           w_next_state;

    logic [ACC_TYPE_BITS-1:0]         r_idx;
    logic [SCHED_TASKTYPE_BITS-1:0]   r_type;
    logic [ACC_BITS-1:0]              r_first;
    logic [ACC_BITS-1:0]              r_last;
    logic [ACC_BITS-1:0]              r_off;
    logic [ACC_BITS-1:0]              r_cnt;
    logic [MAX_ACCS-1:0]              r_busy;
    logic [1:0]                       r_code;
    logic [ACC_BITS-1:0]              r_id;

    logic [SCHED_TASKTYPE_BITS-1:0]   w_dout_type;
    logic [ACC_BITS-1:0]              w_dout_first;
    logic [ACC_BITS-1:0]              w_dout_last;
    logic                             w_match;
    logic [ACC_TYPE_BITS:0]           w_idx_inc;
    logic                             w_last_entry;
    logic [ACC_BITS-1:0]              w_cand;
    logic                             w_cand_free;
    logic [ACC_BITS-1:0]              w_start_off;
    logic                             w_grant_hs;
    logic [MAX_ACCS-1:0]              w_free_mask;
    logic [MAX_ACCS-1:0]              w_grant_mask;
    logic                             w_unused;

    // Field extraction from the scheduling data word
    assign w_dout_type  = scheduleData_portB_dout[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
    assign w_dout_first = scheduleData_portB_dout[SCHED_DATA_ACCID_L +: ACC_BITS];
    assign w_dout_last  = scheduleData_portB_dout[SCHED_DATA_COUNT_L +: ACC_BITS];
    assign w_unused     = &{1'b0, scheduleData_portB_dout};

    assign w_match      = (w_dout_type == r_type);
    assign w_idx_inc    = {1'b0, r_idx} + 1'b1;
    // Also stop at the end of the table so an oversized count cannot loop
    assign w_last_entry = (w_idx_inc == num_acc_types) ||
                          (w_idx_inc == (ACC_TYPE_BITS+1)'(MAX_ACC_TYPES));

    // Candidate ID wraps modulo 2^ACC_BITS
    assign w_cand       = r_first + r_off;
    assign w_cand_free  = ~r_busy[w_cand];

    assign w_grant_hs   = (r_state == S_RESP) && resp_ready && (r_code == c_RESP_GRANT);
    assign w_free_mask  = free_valid ? (MAX_ACCS'(1) << free_acc_id) : '0;
    assign w_grant_mask = w_grant_hs ? (MAX_ACCS'(1) << r_id) : '0;

`ifdef SCHED_ROUND_ROBIN_EN
    logic [ACC_BITS-1:0] r_rr [MAX_ACC_TYPES];
    logic [ACC_BITS-1:0] w_rr_cur;

    assign w_rr_cur = r_rr[r_idx];

    // Resume one past the last granted offset; a pointer at or beyond the
    // end of the range (including a stale one) restarts the search at 0
    always_comb begin
        w_start_off = '0;
        if (w_rr_cur < w_dout_last) begin
            w_start_off = w_rr_cur + 1'b1;
        end
    end

    // Remember the granted offset for the type once the grant is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_ACC_TYPES; i++) begin
                r_rr[i] <= '0;
            end
        end else if (w_grant_hs) begin
            r_rr[r_idx] <= r_off;
        end
    end
`else
    // Lowest free instance first
    assign w_start_off = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = (num_acc_types == '0) ? S_RESP : S_LOOKUP_ISSUE;
                end
            end
            S_LOOKUP_ISSUE: begin
                w_next_state = S_LOOKUP_CHECK;
            end
            S_LOOKUP_CHECK: begin
                if (w_match) begin
                    w_next_state = S_SEARCH;
                end else if (w_last_entry) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_LOOKUP_ISSUE;
                end
            end
            S_SEARCH: begin
                if (w_cand_free || (r_cnt == r_last)) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Lookup / search datapath and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_type  <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_code  <= c_RESP_GRANT;
            r_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_type <= req_task_type;
                        r_idx  <= '0;
                        if (num_acc_types == '0) begin
                            r_code <= c_RESP_UNKNOWN;
                            r_id   <= '0;
                        end
                    end
                end
                S_LOOKUP_CHECK: begin
                    if (w_match) begin
                        r_first <= w_dout_first;
                        r_last  <= w_dout_last;
                        r_off   <= w_start_off;
                        r_cnt   <= '0;
                    end else if (w_last_entry) begin
                        r_code <= c_RESP_UNKNOWN;
                        r_id   <= '0;
                    end else begin
                        r_idx <= w_idx_inc[ACC_TYPE_BITS-1:0];
                    end
                end
                S_SEARCH: begin
                    if (w_cand_free) begin
                        r_code <= c_RESP_GRANT;
                        r_id   <= w_cand;
                    end else if (r_cnt == r_last) begin
                        r_code <= c_RESP_BUSY;
                        r_id   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_off <= (r_off == r_last) ? '0 : r_off + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_code <= c_RESP_GRANT;
                        r_id   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Busy bitmap: release first, then a consumed grant sets its bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_free_mask) | w_grant_mask;
        end
    end

    assign req_ready               = (r_state == S_IDLE);
    assign resp_valid              = (r_state == S_RESP);
    assign resp_code               = r_code;
    assign resp_acc_id             = r_id;
    assign scheduleData_portB_en   = (r_state == S_LOOKUP_ISSUE);
    assign scheduleData_portB_addr = r_idx;
    assign busy_mask               = r_busy;

endmodule
`default_nettype wire
